// File: rtl/seven_segment_monitor_if.sv
// Seven-segment display bus: four active-low digit enables, seven active-high
// segment lines, and the recovered-value result from the monitor.
interface seven_segment_monitor_if;
  logic       seg0_en, seg1_en, seg2_en, seg3_en;
  logic       a_in, b_in, c_in, d_in, e_in, f_in, g_in;
  logic [7:0] binary;
  logic       valid;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output seg0_en, seg1_en, seg2_en, seg3_en,
    output a_in, b_in, c_in, d_in, e_in, f_in, g_in,
    input  binary, valid, error, err_code
  );

  modport slave (
    input  seg0_en, seg1_en, seg2_en, seg3_en,
    input  a_in, b_in, c_in, d_in, e_in, f_in, g_in,
    output binary, valid, error, err_code
  );
endinterface

// File: rtl/seven_segment_monitor.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment display:
// debounces each digit dwell, decodes glyphs and rebuilds the signed 8-bit value.
module seven_segment_monitor #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 2**20,
  parameter int TO_W    = 21
) (
  input logic              clk,
  input logic              rst,
  seven_segment_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, EMIT} state_t;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [10:0] IN_IDLE = 11'h780;

  state_t          state, state_nxt;
  logic [10:0]     in_q, prev_q, pend_vec, ev_vec;
  logic [CW-1:0]   stb_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            stable, hit, pend, ev_live;
  logic [3:0]      en_low, flags;
  logic [6:0]      glyph;
  logic [4:0]      dg;
  logic            multi, bad;
  logic [3:0]      d_hun, d_ten, d_one;
  logic            sgn;
  logic [9:0]      mag;
  logic            in_range;
  logic [7:0]      bin_nxt, bin_q;
  logic            take, clr, fault, emit_ok;
  logic [1:0]      fault_code, code_q;
  logic            valid_q, error_q;

  function automatic logic [4:0] dec(input logic [6:0] g);
    case (g)
      7'h7E:   dec = {1'b1, 4'd0};
      7'h30:   dec = {1'b1, 4'd1};
      7'h6D:   dec = {1'b1, 4'd2};
      7'h79:   dec = {1'b1, 4'd3};
      7'h33:   dec = {1'b1, 4'd4};
      7'h5B:   dec = {1'b1, 4'd5};
      7'h5F:   dec = {1'b1, 4'd6};
      7'h70:   dec = {1'b1, 4'd7};
      7'h7F:   dec = {1'b1, 4'd8};
      7'h7B:   dec = {1'b1, 4'd9};
      default: dec = 5'd0;
    endcase
  endfunction

  // Input register and dwell stability counter; in_q = {en3..en0, a..g}.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= IN_IDLE;
      prev_q  <= IN_IDLE;
      stb_cnt <= '0;
    end else begin
      in_q    <= {bus.seg3_en, bus.seg2_en, bus.seg1_en, bus.seg0_en,
                  bus.a_in, bus.b_in, bus.c_in, bus.d_in, bus.e_in, bus.f_in, bus.g_in};
      prev_q  <= in_q;
      if (!stable)
        stb_cnt <= '0;
      else if (stb_cnt != CW'(SETTLE))
        stb_cnt <= stb_cnt + 1'b1;
    end
  end

  assign stable = (in_q == prev_q);
  // Fires once per dwell: the cycle the counter steps onto SETTLE-1.
  assign hit    = stable && (stb_cnt == CW'(SETTLE - 2));

  // A dwell that settles while COMPUTE/EMIT are busy is held and replayed in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_vec <= IN_IDLE;
    end else if (state == COMPUTE || state == EMIT) begin
      if (hit) begin
        pend     <= 1'b1;
        pend_vec <= in_q;
      end
    end else begin
      pend <= 1'b0;
    end
  end

  assign ev_live = hit | pend;

  always_comb begin
    ev_vec = pend ? pend_vec : in_q;
    en_low = ~ev_vec[10:7];
    glyph  = ev_vec[6:0];
    dg     = dec(glyph);
    multi  = (en_low != 4'd0) && !$onehot(en_low);
    bad    = 1'b0;
    case (en_low)
      4'b1000:          bad = (glyph != 7'h00) && (glyph != 7'h01);
      4'b0100, 4'b0010: bad = !dg[4] && (glyph != 7'h00);
      4'b0001:          bad = !dg[4];
      default:          bad = 1'b0;
    endcase
  end

  always_comb begin
    mag      = 10'(d_hun) * 10'd100 + 10'(d_ten) * 10'd10 + 10'(d_one);
    in_range = sgn ? (mag <= 10'd128) : (mag <= 10'd127);
    bin_nxt  = sgn ? (8'd0 - mag[7:0]) : mag[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    clr        = 1'b0;
    fault      = 1'b0;
    fault_code = 2'd0;
    emit_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (ev_live && en_low != 4'd0) begin
          if (multi || bad) begin
            fault      = 1'b1;
            fault_code = multi ? 2'd2 : 2'd0;
            clr        = 1'b1;
          end else begin
            take      = 1'b1;
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          fault      = 1'b1;
          fault_code = 2'd3;
          clr        = 1'b1;
          state_nxt  = IDLE;
        end else if (ev_live && (multi || bad)) begin
          fault      = 1'b1;
          fault_code = multi ? 2'd2 : 2'd0;
          clr        = 1'b1;
          state_nxt  = IDLE;
        end else begin
          take = ev_live && (en_low != 4'd0);
          if (&flags) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        state_nxt = EMIT;
        if (in_range) begin
          emit_ok = 1'b1;
        end else begin
          fault      = 1'b1;
          fault_code = 2'd1;
        end
      end
      EMIT: begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags   <= '0;
      d_hun   <= '0;
      d_ten   <= '0;
      d_one   <= '0;
      sgn     <= 1'b0;
      to_cnt  <= '0;
      bin_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= emit_ok;
      error_q <= fault;
      if (fault)   code_q <= fault_code;
      if (emit_ok) bin_q  <= bin_nxt;
      to_cnt <= (state == COLLECT) ? to_cnt + 1'b1 : '0;
      if (clr) begin
        flags <= '0;
      end else if (take) begin
        flags <= flags | en_low;
        if (en_low[3]) sgn   <= glyph[0];
        if (en_low[2]) d_hun <= dg[3:0];
        if (en_low[1]) d_ten <= dg[3:0];
        if (en_low[0]) d_one <= dg[3:0];
      end
    end
  end

  assign bus.binary   = bin_q;
  assign bus.valid    = valid_q;
  assign bus.error    = error_q;
  assign bus.err_code = code_q;
endmodule

// File: tb/tb_seven_segment_monitor.sv
// Directed bench for seven_segment_monitor: table of whole frames plus
// hand-written glitch, multi-enable, mid-frame reset and timeout sequences.
module tb_seven_segment_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_monitor_if bus();

  seven_segment_monitor #(.SETTLE(4), .TIMEOUT(64), .TO_W(21)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [6:0] sg, hu, te, on;
    logic       exp_v;
    logic [1:0] exp_code;
    logic [7:0] exp_bin;
    int         step;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, vcnt = 0, ecnt = 0, v_cyc = 0, e_cyc = 0;

  // Pulse monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.valid) begin vcnt++; v_cyc = cyc; end
    if (bus.error) begin ecnt++; e_cyc = cyc; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] g, input int n);
    {bus.seg3_en, bus.seg2_en, bus.seg1_en, bus.seg0_en} = en;
    {bus.a_in, bus.b_in, bus.c_in, bus.d_in, bus.e_in, bus.f_in, bus.g_in} = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input vec_t v);
    int v0, e0, c0;
    v0 = vcnt;
    e0 = ecnt;
    drive(4'b0111, v.sg, 8);
    drive(4'b1011, v.hu, 8);
    drive(4'b1101, v.te, 8);
    c0 = cyc;
    drive(4'b1110, v.on, 8);
    check({name, " valid count"}, vcnt - v0, {31'd0, v.exp_v});
    check({name, " error count"}, ecnt - e0, {31'd0, !v.exp_v});
    if (v.exp_v) check({name, " valid latency"}, v_cyc - c0, v.step);
    else         check({name, " error latency"}, e_cyc - c0, v.step);
    check({name, " binary"}, bus.binary, v.exp_bin);
    if (!v.exp_v) check({name, " err_code"}, bus.err_code, v.exp_code);
  endtask

  vec_t tbl [12];

  initial begin
    vec_t f;
    int v0, e0, c0;
    tbl[0]  = '{7'h01, 7'h7E, 7'h33, 7'h6D, 1'b1, 2'd0, 8'hD6, 7};  // -42
    tbl[1]  = '{7'h00, 7'h30, 7'h6D, 7'h70, 1'b1, 2'd0, 8'h7F, 7};  // +127
    tbl[2]  = '{7'h01, 7'h30, 7'h6D, 7'h7F, 1'b1, 2'd0, 8'h80, 7};  // -128
    tbl[3]  = '{7'h00, 7'h30, 7'h6D, 7'h7B, 1'b0, 2'd1, 8'h80, 7};  // +129
    tbl[4]  = '{7'h01, 7'h30, 7'h6D, 7'h7B, 1'b0, 2'd1, 8'h80, 7};  // -129
    tbl[5]  = '{7'h00, 7'h30, 7'h7E, 7'h7E, 1'b1, 2'd0, 8'h64, 7};  // +100
    tbl[6]  = '{7'h01, 7'h00, 7'h00, 7'h7E, 1'b1, 2'd0, 8'h00, 7};  // -0
    tbl[7]  = '{7'h00, 7'h7F, 7'h7F, 7'h7F, 1'b0, 2'd1, 8'h00, 7};  // 999
    tbl[8]  = '{7'h00, 7'h00, 7'h00, 7'h78, 1'b0, 2'd0, 8'h00, 5};  // ones=abcd
    tbl[9]  = '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 2'd0, 8'h00, 5};  // blank ones
    tbl[10] = '{7'h01, 7'h00, 7'h30, 7'h7F, 1'b1, 2'd0, 8'hEE, 7};  // -18
    tbl[11] = '{7'h01, 7'h00, 7'h00, 7'h30, 1'b1, 2'd0, 8'hFF, 7};  // -1

    {bus.seg3_en, bus.seg2_en, bus.seg1_en, bus.seg0_en} = 4'hF;
    {bus.a_in, bus.b_in, bus.c_in, bus.d_in, bus.e_in, bus.f_in, bus.g_in} = 7'h00;
    repeat (3) @(negedge clk);
    check("reset binary",   bus.binary,   8'h00);
    check("reset valid",    bus.valid,    1'b0);
    check("reset error",    bus.error,    1'b0);
    check("reset err_code", bus.err_code, 2'd0);
    rst = 1'b0;
    drive(4'hF, 7'h00, 4);

    for (int i = 0; i < 12; i++) run_frame($sformatf("frame%0d", i), tbl[i]);

    // Two enables low together, then a clean +5 frame.
    v0 = vcnt; e0 = ecnt; c0 = cyc;
    drive(4'b1100, 7'h33, 6);
    drive(4'hF, 7'h00, 4);
    check("multi error count", ecnt - e0, 1);
    check("multi err_code",    bus.err_code, 2'd2);
    check("multi error latency", e_cyc - c0, 5);
    check("multi no valid",    vcnt - v0, 0);
    f = '{7'h00, 7'h00, 7'h00, 7'h5B, 1'b1, 2'd0, 8'h05, 7};
    run_frame("after multi", f);

    // Short segment glitch at the start of the tens dwell.
    v0 = vcnt; e0 = ecnt;
    drive(4'b0111, 7'h00, 8);
    drive(4'b1011, 7'h00, 8);
    drive(4'b1101, 7'h7F, 3);
    drive(4'b1101, 7'h33, 8);
    c0 = cyc;
    drive(4'b1110, 7'h6D, 8);
    check("glitch valid count", vcnt - v0, 1);
    check("glitch error count", ecnt - e0, 0);
    check("glitch latency",     v_cyc - c0, 7);
    check("glitch binary",      bus.binary, 8'h2A);

    // Reset after two captures, then only the remaining two digits.
    v0 = vcnt; e0 = ecnt;
    drive(4'b0111, 7'h01, 8);
    drive(4'b1011, 7'h30, 8);
    rst = 1'b1;
    drive(4'hF, 7'h00, 1);
    rst = 1'b0;
    drive(4'b1101, 7'h6D, 8);
    drive(4'b1110, 7'h70, 8);
    check("rst no valid",  vcnt - v0, 0);
    check("rst no error",  ecnt - e0, 0);
    check("rst binary",    bus.binary, 8'h00);
    check("rst err_code",  bus.err_code, 2'd0);
    rst = 1'b1;
    drive(4'hF, 7'h00, 1);
    rst = 1'b0;
    drive(4'hF, 7'h00, 4);

    // Three digits only: timeout 64 cycles after the sign capture.
    v0 = vcnt; e0 = ecnt; c0 = cyc;
    drive(4'b0111, 7'h01, 8);
    drive(4'b1011, 7'h30, 8);
    drive(4'b1101, 7'h6D, 8);
    drive(4'hF, 7'h00, 1);
    for (int k = 0; k < 150 && ecnt == e0; k++) @(negedge clk);
    check("timeout error count", ecnt - e0, 1);
    check("timeout latency",     e_cyc - c0, 69);
    check("timeout err_code",    bus.err_code, 2'd3);
    check("timeout no valid",    vcnt - v0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
